// File: rtl/vector_stim_checker.sv
// Stimulus/response engine: resets a 4-in/1-out DUT, plays a table of ABCD
// vectors with per-entry dwell, samples Z at each vector's end and reports.
module vector_stim_checker #(
  parameter int NUM_VEC    = 16,
  parameter int AW         = 4,
  parameter int DW         = 4,
  parameter int RST_CYCLES = 1,
  parameter int ECW        = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [DW+4:0]   cfg_wdata,
  input  logic [AW:0]     vec_count,
  input  logic            start,
  input  logic            z_in,
  output logic            a,
  output logic            b,
  output logic            c,
  output logic            d,
  output logic            dut_rst,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ECW-1:0]  err_count,
  output logic [AW:0]     first_err_idx
);

  localparam int           RCW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_INIT = RCW'(RST_CYCLES - 1);
  localparam logic [AW:0]  NUM_VEC_W = (AW + 1)'(NUM_VEC);
  localparam logic [AW:0]  IDX_NONE  = '1;
  localparam logic [ECW-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {IDLE, DUTRST, APPLY, DONE} state_t;

  state_t             state_q, state_d;
  logic [DW+4:0]      tbl_q [2**AW];
  logic [AW:0]        idx_q, idx_d, vcnt_q, vcnt_d, fei_q, fei_d;
  logic [DW-1:0]      dwell_q, dwell_d;
  logic [RCW-1:0]     rcnt_q, rcnt_d;
  logic [3:0]         abcd_q, abcd_d;
  logic [ECW-1:0]     err_q, err_d;
  logic               dut_rst_q, dut_rst_d, busy_q, busy_d;
  logic               done_q, done_d, pass_q, pass_d;
  logic [AW:0]        idx_inc;

  assign idx_inc = idx_q + 1'b1;

  // Table is deliberately left out of reset so a programmed pattern survives it.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy_q && ({1'b0, cfg_addr} < NUM_VEC_W))
      tbl_q[cfg_addr] <= cfg_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      vcnt_q    <= '0;
      fei_q     <= IDX_NONE;
      dwell_q   <= '0;
      rcnt_q    <= '0;
      abcd_q    <= '0;
      err_q     <= '0;
      dut_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      vcnt_q    <= vcnt_d;
      fei_q     <= fei_d;
      dwell_q   <= dwell_d;
      rcnt_q    <= rcnt_d;
      abcd_q    <= abcd_d;
      err_q     <= err_d;
      dut_rst_q <= dut_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    vcnt_d    = vcnt_q;
    fei_d     = fei_q;
    dwell_d   = dwell_q;
    rcnt_d    = rcnt_q;
    abcd_d    = abcd_q;
    err_d     = err_q;
    dut_rst_d = dut_rst_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = DUTRST;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = '0;
          fei_d     = IDX_NONE;
          dut_rst_d = 1'b1;
          abcd_d    = '0;
          idx_d     = '0;
          rcnt_d    = RST_INIT;
          vcnt_d    = (vec_count > NUM_VEC_W) ? NUM_VEC_W : vec_count;
        end
      end
      DUTRST: begin
        if (rcnt_q == '0) begin
          if (vcnt_q == '0) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d   = APPLY;
            dut_rst_d = 1'b0;
            abcd_d    = tbl_q[0][3:0];
            dwell_d   = tbl_q[0][DW+4:5];
          end
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      APPLY: begin
        if (dwell_q == '0) begin
          // Last dwell cycle: Z is expected to have settled by now.
          if (z_in != tbl_q[idx_q[AW-1:0]][4]) begin
            if (err_q != ERR_MAX) err_d = err_q + 1'b1;
            if (fei_q == IDX_NONE) fei_d = idx_q;
          end
          idx_d = idx_inc;
          if (idx_inc == vcnt_q) begin
            state_d   = DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pass_d    = (err_d == '0);
            abcd_d    = '0;
            dut_rst_d = 1'b1;
          end else begin
            abcd_d  = tbl_q[idx_inc[AW-1:0]][3:0];
            dwell_d = tbl_q[idx_inc[AW-1:0]][DW+4:5];
          end
        end else begin
          dwell_d = dwell_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign {a, b, c, d}   = abcd_q;
  assign dut_rst        = dut_rst_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_idx  = fei_q;

endmodule

// File: tb/tb_vector_stim_checker.sv
// Directed bench for vector_stim_checker; a narrow-ECW twin instance covers
// error-count saturation within a single 16-vector run.
module tb_vector_stim_checker;

  logic       clk = 1'b0;
  logic       rst, cfg_we, start, force_z;
  logic [3:0] cfg_addr;
  logic [8:0] cfg_wdata;
  logic [4:0] vec_count;
  logic       z_in;
  logic       a, b, c, d, dut_rst, busy, done, pass;
  logic [7:0] err_count;
  logic [4:0] first_err_idx;
  logic       s_a, s_b, s_c, s_d, s_dut_rst, s_busy, s_done, s_pass;
  logic [2:0] s_err_count;
  logic [4:0] s_first_err_idx;

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  // Stand-in DUT: Z = B & C & ~D, so 0111 -> 0 and 0110 -> 1.
  assign z_in = force_z ? 1'b0 : (b & c & ~d);

  vector_stim_checker dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .vec_count(vec_count), .start(start), .z_in(z_in),
    .a(a), .b(b), .c(c), .d(d), .dut_rst(dut_rst), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_idx(first_err_idx)
  );

  vector_stim_checker #(.ECW(3)) dut_sat (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .vec_count(vec_count), .start(start), .z_in(z_in),
    .a(s_a), .b(s_b), .c(s_c), .d(s_d), .dut_rst(s_dut_rst), .busy(s_busy),
    .done(s_done), .pass(s_pass), .err_count(s_err_count),
    .first_err_idx(s_first_err_idx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [8:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go(input logic [4:0] vc);
    start = 1'b1; vec_count = vc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done_timeout", done, 1);
  endtask

  function automatic logic [8:0] ent(input logic [3:0] dw, input logic ez, input logic [3:0] v);
    return {dw, ez, v};
  endfunction

  initial begin
    rst = 1'b0; cfg_we = 1'b0; start = 1'b0; force_z = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; vec_count = '0;
    tick();
    chk("rst_abcd", {a, b, c, d}, 4'b0000);
    chk("rst_dut_rst", dut_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fei", first_err_idx, 5'h1F);
    rst = 1'b1;
    tick();

    // Two-vector run with a matching DUT
    wr(4'd0, ent(4'd0, 1'b0, 4'b0111));
    wr(4'd1, ent(4'd1, 1'b1, 4'b0110));
    go(5'd2);
    chk("r1_busy", busy, 1);
    chk("r1_dutrst", dut_rst, 1);
    tick();
    chk("r1_dutrst_off", dut_rst, 0);
    chk("r1_v0", {a, b, c, d}, 4'b0111);
    tick();
    chk("r1_v1a", {a, b, c, d}, 4'b0110);
    tick();
    chk("r1_v1b", {a, b, c, d}, 4'b0110);
    chk("r1_not_done", done, 0);
    tick();
    chk("r1_done", done, 1);
    chk("r1_pass", pass, 1);
    chk("r1_err", err_count, 0);
    chk("r1_busy_off", busy, 0);
    chk("r1_abcd0", {a, b, c, d}, 4'b0000);
    chk("r1_dutrst_on", dut_rst, 1);
    chk("r1_fei", first_err_idx, 5'h1F);

    // Same table, Z stuck low: vector 1 miscompares
    force_z = 1'b1;
    go(5'd2);
    chk("r2_done_clr", done, 0);
    wait_done(10, cyc);
    chk("r2_len", cyc, 4);
    chk("r2_err", err_count, 1);
    chk("r2_fei", first_err_idx, 1);
    chk("r2_pass", pass, 0);
    force_z = 1'b0;

    // Empty run
    go(5'd0);
    chk("r3_busy", busy, 1);
    tick();
    chk("r3_done", done, 1);
    chk("r3_pass", pass, 1);
    chk("r3_abcd", {a, b, c, d}, 4'b0000);
    chk("r3_err", err_count, 0);

    // Writes and start while busy are ignored
    go(5'd2);
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = ent(4'd3, 1'b1, 4'b0000);
    start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    chk("r4_v0", {a, b, c, d}, 4'b0111);
    tick();
    chk("r4_v1", {a, b, c, d}, 4'b0110);
    tick();
    tick();
    chk("r4_done", done, 1);
    chk("r4_pass", pass, 1);

    // Abort mid-APPLY; table contents survive the reset
    go(5'd2);
    tick();
    chk("r5_v0_tbl_kept", {a, b, c, d}, 4'b0111);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("r5_rst_abcd", {a, b, c, d}, 4'b0000);
    chk("r5_rst_dutrst", dut_rst, 1);
    chk("r5_rst_busy", busy, 0);
    chk("r5_rst_done", done, 0);
    chk("r5_rst_fei", first_err_idx, 5'h1F);
    tick();
    chk("r5_idle_busy", busy, 0);

    // Full table, all miscompare; vec_count above depth clamps to 16
    for (int i = 0; i < 16; i++) wr(4'(i), ent(4'd0, 1'b1, 4'(i)));
    force_z = 1'b1;
    for (int r = 0; r < 3; r++) begin
      go(5'd31);
      wait_done(40, cyc);
      chk("r6_len", cyc, 17);
      chk("r6_err", err_count, 16);
      chk("r6_fei", first_err_idx, 0);
      chk("r6_pass", pass, 0);
      chk("r6_sat_err", s_err_count, 7);
      chk("r6_sat_done", s_done, 1);
    end
    force_z = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
